fixed_point_sqrt_seq: RTL and testbench
=======================================

FIXED_POINT_SQRT_SEQ -- requirements
Module: fixed_point_sqrt_seq

Interface
REQ-001 SHALL have parameter WIDTH, default `WIDTH (32), meaning operand/result width in bits.
REQ-002 SHALL have parameter SCALE, default `SCALE (17), meaning fractional bits of operand and result.
REQ-003 SHALL have parameter ROUND, default 0, meaning 0 = truncate, 1 = round-to-nearest.
REQ-004 SHALL have parameter SIGNED, default 1, meaning 1 = Operand MSB is a sign bit, 0 = Operand is unsigned.
REQ-005 SHALL have port Clock, input, 1 bit, meaning the single clock; all logic is on the rising edge.
REQ-006 SHALL have port Reset, input, 1 bit, meaning synchronous, active-low reset.
REQ-007 SHALL have port Operand, input, WIDTH bits, meaning the fixed-point radicand.
REQ-008 SHALL have port iInputReady, input, 1 bit, meaning Operand is valid this cycle.
REQ-009 SHALL have port oBusy, output, 1 bit, meaning a computation is in progress and new requests are ignored.
REQ-010 SHALL have port OutputReady, output, 1 bit, meaning a one-cycle pulse that marks Result/oError as new.
REQ-011 SHALL have port Result, output, WIDTH bits, meaning sqrt(Operand) in the same fixed-point format.
REQ-012 SHALL have port oError, output, 1 bit, meaning the operand was negative (SIGNED=1 only).

Function
REQ-013 SHALL compute the integer square root of radicand R = Operand << SCALE, zero-padded to RW = WIDTH+SCALE rounded up to even; the iteration count is N = RW/2 (25 at default).
REQ-014 SHALL use a restoring digit-by-digit algorithm: one result bit per cycle, MSB first, with remainder width N+2 and no multipliers.
REQ-015 SHALL use a state machine with states IDLE -> CALC (exactly N cycles) -> DONE (1 cycle) -> IDLE.
REQ-016 SHALL, in IDLE with iInputReady=1, capture Operand and enter CALC on that edge; oBusy SHALL be high in CALC and DONE.
REQ-017 SHALL assert OutputReady for exactly one cycle in DONE, N+1 cycles after the accepting edge; Result and oError SHALL update on the same edge that OutputReady rises.
REQ-018 SHALL hold Result and oError stable from one completion until the next completion or reset.
REQ-019 SHALL ignore iInputReady while oBusy=1; no queuing, and the operand in flight is unaffected.
REQ-020 SHALL, with ROUND=1, increment the root when final remainder > root; if the increment overflows WIDTH bits, Result SHALL saturate to all ones.
REQ-021 SHALL, with SIGNED=1 and Operand MSB=1, set oError=1 and Result=0, with the same N+1 latency so that timing is data-independent.
REQ-022 SHALL zero-extend the root to WIDTH bits; with SIGNED=0 the full unsigned range SHALL be valid.
REQ-023 SHALL give Operand=0 the result Result=0, oError=0.
REQ-024 SHALL allow back-to-back operation: iInputReady in the cycle after DONE (IDLE) is accepted, so throughput is one result per N+2 cycles.

Reset
REQ-025 SHALL, while Reset=0 at a rising edge, force state=IDLE, oBusy=0, OutputReady=0, Result=0, oError=0, and clear internal root/remainder/counter.
REQ-026 SHALL, on reset asserted mid-CALC or in DONE, abandon the operation with no OutputReady pulse; the first request after reset release SHALL be accepted normally.

Structure
REQ-027 SHALL take WIDTH and SCALE defaults from the shared definitions file (`WIDTH, `SCALE); state encodings SHALL be local parameters.
REQ-028 SHALL place one iteration (trial subtract, select, shift) in a combinational sub-module sqrt_digit_step, parametrised by remainder width.
REQ-029 SHALL use no LUT, so that any in-range operand is valid.

Verification
REQ-030 SHALL cover: Operand=0x00080000 (4.0), ROUND=0 -> Result=0x00040000, OutputReady exactly 26 cycles after accept.
REQ-031 SHALL cover: Operand=0x00040000 (2.0) -> Result=0x0002D413 with ROUND=0, 0x0002D414 with ROUND=1.
REQ-032 SHALL cover: Operand=0x00C80000 (100.0) -> 0x00140000; Operand=0x00008000 (0.25) -> 0x00010000; Operand=0 -> 0.
REQ-033 SHALL cover: SIGNED=1, Operand=0x80000000 -> oError=1, Result=0, same latency; the next valid op clears oError.
REQ-034 SHALL cover: iInputReady held high throughout -> only IDLE-cycle requests accepted, one result per 27 cycles, mid-CALC operand changes have no effect.
REQ-035 SHALL cover: Reset=0 at CALC cycle 10 -> no OutputReady, all outputs 0, and a subsequent 4.0 request returns 0x00040000.

Source files
------------

// File: rtl/fixed_point_sqrt_seq_pkg.sv
// Shared sizing defaults and helpers for the sequential fixed-point square root.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef SCALE
`define SCALE 17
`endif

package fixed_point_sqrt_seq_pkg;

  typedef logic [1:0] sqrt_state_t;

  // Radicand is WIDTH+SCALE bits padded to an even count; one root bit per bit pair.
  function automatic int sqrt_iters(input int width, input int scale);
    return (width + scale + 1) / 2;
  endfunction

endpackage

// File: rtl/sqrt_digit_step.sv
// One restoring square-root iteration: bring down two radicand bits, trial subtract, select.
module sqrt_digit_step
  import fixed_point_sqrt_seq_pkg::*;
#(
  parameter int REMW = 27
) (
  input  logic [REMW-1:0] rem,
  input  logic [1:0]      bits,
  input  logic [REMW-3:0] root,
  output logic [REMW-1:0] rem_nx,
  output logic [REMW-3:0] root_nx
);

  localparam int QW = REMW - 2;

  logic [REMW-1:0]      shifted;
  logic signed [REMW:0] diff;

  // The remainder never exceeds twice the partial root, so its top two bits are always zero here.
  assign shifted = REMW'({rem, bits});
  assign diff    = $signed({1'b0, shifted}) - $signed({1'b0, root, 2'b01});
  assign root_nx = QW'({root, ~diff[REMW]});
  assign rem_nx  = diff[REMW] ? shifted : diff[REMW-1:0];

endmodule

// File: rtl/fixed_point_sqrt_seq.sv
// Sequential fixed-point square root: one root bit per cycle, fixed N+1 cycle latency.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef SCALE
`define SCALE 17
`endif

module fixed_point_sqrt_seq
  import fixed_point_sqrt_seq_pkg::*;
#(
  parameter int WIDTH  = `WIDTH,
  parameter int SCALE  = `SCALE,
  parameter int ROUND  = 0,
  parameter int SIGNED = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Operand,
  input  logic             iInputReady,
  output logic             oBusy,
  output logic             OutputReady,
  output logic [WIDTH-1:0] Result,
  output logic             oError
);

  localparam int N    = sqrt_iters(WIDTH, SCALE);
  localparam int RW   = 2 * N;
  localparam int REMW = N + 2;
  localparam int CW   = $clog2(N + 1);
  localparam int WX   = WIDTH + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  sqrt_state_t     state;
  logic [RW-1:0]   rad;
  logic [N-1:0]    root;
  logic [N-1:0]    root_nx;
  logic [REMW-1:0] rem;
  logic [REMW-1:0] rem_nx;
  logic [CW-1:0]   cnt;
  logic            err;

  // Round to nearest: (q+0.5)^2 < R reduces to remainder > q.
  function automatic logic [WX-1:0] round_root(input logic [N-1:0] q, input logic [REMW-1:0] r);
    logic [WX-1:0] qx;
    qx = WX'(q);
    if ((ROUND != 0) && (r > REMW'(q))) qx = qx + WX'(1);
    return qx;
  endfunction

  function automatic logic [WIDTH-1:0] sat_width(input logic [WX-1:0] v);
    return v[WIDTH] ? '1 : v[WIDTH-1:0];
  endfunction

  sqrt_digit_step #(.REMW(REMW)) u_step (
    .rem     (rem),
    .bits    (rad[RW-1 -: 2]),
    .root    (root),
    .rem_nx  (rem_nx),
    .root_nx (root_nx)
  );

  assign oBusy = (state != ST_IDLE);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      rad         <= '0;
      root        <= '0;
      rem         <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      OutputReady <= 1'b0;
      Result      <= '0;
      oError      <= 1'b0;
    end else begin
      OutputReady <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iInputReady) begin
            // Negative operands still run the full iteration count so latency is data-independent.
            rad   <= RW'(Operand) << SCALE;
            root  <= '0;
            rem   <= '0;
            cnt   <= '0;
            err   <= (SIGNED != 0) && Operand[WIDTH-1];
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          rad  <= rad << 2;
          root <= root_nx;
          rem  <= rem_nx;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          Result      <= err ? '0 : sat_width(round_root(root, rem));
          oError      <= err;
          OutputReady <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_sqrt_seq.sv
// Self-checking bench: truncating/signed and rounding/unsigned instances against an arithmetic model.
module tb_fixed_point_sqrt_seq;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Operand = '0;
  logic        iInputReady = 1'b0;

  logic        busy0, rdy0, err0;
  logic        busy1, rdy1, err1;
  logic [31:0] res0, res1;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  fixed_point_sqrt_seq #(.WIDTH(32), .SCALE(17), .ROUND(0), .SIGNED(1)) dut0 (
    .Clock(Clock), .Reset(Reset), .Operand(Operand), .iInputReady(iInputReady),
    .oBusy(busy0), .OutputReady(rdy0), .Result(res0), .oError(err0)
  );

  fixed_point_sqrt_seq #(.WIDTH(32), .SCALE(17), .ROUND(1), .SIGNED(0)) dut1 (
    .Clock(Clock), .Reset(Reset), .Operand(Operand), .iInputReady(iInputReady),
    .oBusy(busy1), .OutputReady(rdy1), .Result(res1), .oError(err1)
  );

  // Reference: exact integer sqrt of Operand*2^17 by binary search, then optional nearest rounding.
  function automatic void model(input logic [31:0] op, input bit rnd, input bit sgn,
                                output logic [31:0] res, output logic err);
    longint unsigned r, lo, hi, mid, q;
    if (sgn && op[31]) begin
      res = '0;
      err = 1'b1;
      return;
    end
    err = 1'b0;
    r  = {32'd0, op} << 17;
    lo = 0;
    hi = 64'h0000_0000_0400_0000;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= r) lo = mid;
      else hi = mid - 1;
    end
    q = lo;
    if (rnd && (4 * r > (2 * q + 1) * (2 * q + 1))) q = q + 1;
    if (q > 64'h0000_0000_FFFF_FFFF) q = 64'h0000_0000_FFFF_FFFF;
    res = q[31:0];
  endfunction

  task automatic do_op(input logic [31:0] op, output int lat, output logic busy_acc,
                       output logic [31:0] r0, output logic e0, output logic [31:0] r1,
                       output logic e1, output logic rdy1_seen);
    lat = -1; r0 = '0; e0 = 1'b0; r1 = '0; e1 = 1'b0; rdy1_seen = 1'b0;
    @(negedge Clock);
    Operand = op;
    iInputReady = 1'b1;
    @(posedge Clock); #1;
    busy_acc = busy0;
    iInputReady = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge Clock); #1;
      if (rdy0) begin
        lat = k; r0 = res0; e0 = err0; r1 = res1; e1 = err1; rdy1_seen = rdy1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    iInputReady = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy0 got=%b want=0", busy0); end
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL rst_rdy0 got=%b want=0", rdy0); end
    checks++; if (res0 !== 32'd0) begin failures++; $display("FAIL rst_res0 got=%h want=0", res0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL rst_err0 got=%b want=0", err0); end
    checks++; if (busy1 !== 1'b0 || rdy1 !== 1'b0 || res1 !== 32'd0 || err1 !== 1'b0) begin
      failures++; $display("FAIL rst_dut1 got=%b%b%h%b want=0", busy1, rdy1, res1, err1);
    end
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] t_op [5];
    logic [31:0] t_e0 [5];
    logic [31:0] t_e1 [5];
    int lat; logic ba, e0, e1, r1s; logic [31:0] r0, r1;
    t_op = '{32'h0008_0000, 32'h0004_0000, 32'h00C8_0000, 32'h0000_8000, 32'h0000_0000};
    t_e0 = '{32'h0004_0000, 32'h0002_D413, 32'h0014_0000, 32'h0001_0000, 32'h0000_0000};
    t_e1 = '{32'h0004_0000, 32'h0002_D414, 32'h0014_0000, 32'h0001_0000, 32'h0000_0000};
    for (int i = 0; i < 5; i++) begin
      do_op(t_op[i], lat, ba, r0, e0, r1, e1, r1s);
      checks++; if (lat != 26) begin failures++; $display("FAIL dir_latency op=%h got=%0d want=26", t_op[i], lat); end
      checks++; if (ba !== 1'b1) begin failures++; $display("FAIL dir_busy op=%h got=%b want=1", t_op[i], ba); end
      checks++; if (r0 !== t_e0[i] || e0 !== 1'b0) begin
        failures++; $display("FAIL dir_trunc op=%h got=%h/%b want=%h/0", t_op[i], r0, e0, t_e0[i]);
      end
      checks++; if (r1s !== 1'b1 || r1 !== t_e1[i] || e1 !== 1'b0) begin
        failures++; $display("FAIL dir_round op=%h got=%b/%h/%b want=1/%h/0", t_op[i], r1s, r1, e1, t_e1[i]);
      end
    end
  endtask

  task automatic test_negative();
    int lat; logic ba, e0, e1, r1s; logic [31:0] r0, r1, x1; logic xe;
    model(32'h8000_0000, 1'b1, 1'b0, x1, xe);
    do_op(32'h8000_0000, lat, ba, r0, e0, r1, e1, r1s);
    checks++; if (lat != 26) begin failures++; $display("FAIL neg_latency got=%0d want=26", lat); end
    checks++; if (e0 !== 1'b1 || r0 !== 32'd0) begin
      failures++; $display("FAIL neg_error got=%b/%h want=1/00000000", e0, r0);
    end
    checks++; if (r1 !== x1 || e1 !== xe) begin
      failures++; $display("FAIL neg_unsigned got=%h/%b want=%h/%b", r1, e1, x1, xe);
    end
    do_op(32'h0008_0000, lat, ba, r0, e0, r1, e1, r1s);
    checks++; if (e0 !== 1'b0 || r0 !== 32'h0004_0000) begin
      failures++; $display("FAIL neg_clear got=%b/%h want=0/00040000", e0, r0);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      Operand = $urandom;
      @(posedge Clock); #1;
      checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL hold_rdy cyc=%0d got=%b want=0", i, rdy0); end
      checks++; if (res0 !== 32'h0004_0000 || err0 !== 1'b0) begin
        failures++; $display("FAIL hold_res cyc=%0d got=%h/%b want=00040000/0", i, res0, err0);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic ba, e0, e1, r1s, xe0, xe1; logic [31:0] op, r0, r1, x0, x1;
    for (int i = 0; i < 24; i++) begin
      op = $urandom >> $urandom_range(0, 31);
      if (i % 5 == 0) op = $urandom;
      model(op, 1'b0, 1'b1, x0, xe0);
      model(op, 1'b1, 1'b0, x1, xe1);
      do_op(op, lat, ba, r0, e0, r1, e1, r1s);
      checks++; if (lat != 26 || r1s !== 1'b1) begin
        failures++; $display("FAIL rnd_latency op=%h got=%0d/%b want=26/1", op, lat, r1s);
      end
      checks++; if (r0 !== x0 || e0 !== xe0) begin
        failures++; $display("FAIL rnd_trunc op=%h got=%h/%b want=%h/%b", op, r0, e0, x0, xe0);
      end
      checks++; if (r1 !== x1 || e1 !== xe1) begin
        failures++; $display("FAIL rnd_round op=%h got=%h/%b want=%h/%b", op, r1, e1, x1, xe1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seen_op [110];
    int          pc [$];
    logic [31:0] pr0 [$];
    logic        pe0 [$];
    logic [31:0] pr1 [$];
    logic [31:0] x0, x1; logic xe0, xe1;
    @(negedge Clock);
    Operand = $urandom;
    iInputReady = 1'b1;
    for (int c = 0; c < 110; c++) begin
      @(posedge Clock);
      seen_op[c] = Operand;
      #1;
      if (rdy0) begin
        pc.push_back(c); pr0.push_back(res0); pe0.push_back(err0); pr1.push_back(res1);
      end
      @(negedge Clock);
      Operand = $urandom;
      if (c >= 99) iInputReady = 1'b0;
    end
    checks++; if (pc.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", pc.size()); end
    for (int i = 0; i < pc.size() && i < 4; i++) begin
      model(seen_op[27 * i], 1'b0, 1'b1, x0, xe0);
      model(seen_op[27 * i], 1'b1, 1'b0, x1, xe1);
      checks++; if (pc[i] != 26 + 27 * i) begin
        failures++; $display("FAIL b2b_cycle idx=%0d got=%0d want=%0d", i, pc[i], 26 + 27 * i);
      end
      checks++; if (pr0[i] !== x0 || pe0[i] !== xe0) begin
        failures++; $display("FAIL b2b_trunc idx=%0d got=%h/%b want=%h/%b", i, pr0[i], pe0[i], x0, xe0);
      end
      checks++; if (pr1[i] !== x1) begin
        failures++; $display("FAIL b2b_round idx=%0d got=%h want=%h", i, pr1[i], x1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses; logic ba, e0, e1, r1s; logic [31:0] r0, r1;
    do_op(32'h00C8_0000, lat, ba, r0, e0, r1, e1, r1s);
    @(negedge Clock);
    Operand = 32'h0008_0000;
    iInputReady = 1'b1;
    @(posedge Clock); #1;
    iInputReady = 1'b0;
    repeat (10) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;
    checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl got=%b/%b want=0/0", busy0, rdy0);
    end
    checks++; if (res0 !== 32'd0 || err0 !== 1'b0 || res1 !== 32'd0) begin
      failures++; $display("FAIL midrst_data got=%h/%b/%h want=0/0/0", res0, err0, res1);
    end
    @(negedge Clock);
    Reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clock); #1;
      if (rdy0 || rdy1 || busy0) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_quiet got=%0d want=0", pulses); end
    do_op(32'h0008_0000, lat, ba, r0, e0, r1, e1, r1s);
    checks++; if (lat != 26 || r0 !== 32'h0004_0000 || e0 !== 1'b0) begin
      failures++; $display("FAIL midrst_after got=%0d/%h/%b want=26/00040000/0", lat, r0, e0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_negative();
    test_hold();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
